// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-based arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Optional: define FIFO_WR_ARB_STALL_CNT_EN to add a saturating 16-bit full-stall counter (stall_cnt_o).
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 4,
    parameter int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    parameter int unsigned CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    input  logic                      fifo_full_i,
    output logic                      fifo_wr_en_o,
    output logic [DATA_W-1:0]         fifo_wr_data_o,
    output logic                      grant_o,
    output logic [ID_W-1:0]           grant_id_o
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt_o
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_id;
    logic [CNT_W-1:0]  beat_cnt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic              req_g;
    logic              beat;
    logic              last_beat;
    logic [ID_W-1:0]   next_ptr;

    // First requesting index found by searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ
    always_comb begin
        int unsigned idx;
        idx        = 0;
        pick_found = 1'b0;
        pick_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!pick_found && req_i[idx]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'(idx);
            end
        end
    end

    // Request of the granted source, selected without a variable bit-select
    always_comb begin
        req_g = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                req_g = req_i[k];
            end
        end
    end

    assign beat      = (state == ST_BURST) && req_g && !fifo_full_i;
    assign last_beat = beat && (beat_cnt == CNT_W'(MAX_BURST - 1));
    assign next_ptr  = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // Accept/write path is combinational so a beat moves in the cycle it is offered
    always_comb begin
        ack_o          = '0;
        fifo_wr_data_o = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (grant_id == ID_W'(k)) begin
                ack_o[k] = beat;
                if (state == ST_BURST) begin
                    fifo_wr_data_o = data_i[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign fifo_wr_en_o = beat;
    assign grant_o      = (state == ST_BURST);
    assign grant_id_o   = grant_id;

    // Burst FSM: grant selection, beat counting and priority rotation on exit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        grant_id <= pick_id;
                        beat_cnt <= '0;
                        state    <= ST_BURST;
                    end
                end
                ST_BURST: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    if (last_beat || !req_g) begin
                        rr_ptr <= next_ptr;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    // Counts granted-but-blocked cycles, saturating
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if ((state == ST_BURST) && req_g && fifo_full_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the round-robin burst grant rules.
module tb_fifo_wr_arbiter;

    localparam int unsigned NUM_REQ   = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_BURST = 4;
    localparam int unsigned ID_W      = 2;
    localparam int unsigned CNT_W     = 3;

    logic                      clk;
    logic                      rst_i;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        ack_o;
    logic                      fifo_full_i;
    logic                      fifo_wr_en_o;
    logic [DATA_W-1:0]         fifo_wr_data_o;
    logic                      grant_o;
    logic [ID_W-1:0]           grant_id_o;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]               stall_cnt_o;
`endif

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_W    (DATA_W),
        .MAX_BURST (MAX_BURST),
        .ID_W      (ID_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .data_i         (data_i),
        .ack_o          (ack_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_wr_data_o (fifo_wr_data_o),
        .grant_o        (grant_o),
        .grant_id_o     (grant_id_o)
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Model: who (if anyone) holds the port, where the search starts, beats so far
    bit m_busy;
    int m_g;
    int m_rr;
    int m_beats;
    int m_stall;

    // Observed DUT activity
    int dut_wr[$];
    int wr_cyc[$];
    int dut_grants[$];
    int burst_wr[$];
    bit prev_grant;
    int last_step_cyc;
    int first_req_cyc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy     = 1'b0;
        m_g        = 0;
        m_rr       = 0;
        m_beats    = 0;
        m_stall    = 0;
        prev_grant = 1'b0;
    endtask

    task automatic clear_logs();
        dut_wr.delete();
        wr_cyc.delete();
        dut_grants.delete();
        burst_wr.delete();
    endtask

    // One clock: drive, check against the model, log, then advance the model
    task automatic step(input logic [3:0] req, input logic full, input logic [31:0] data);
        logic [3:0] e_ack;
        logic       e_we;
        logic [7:0] e_data;
        @(negedge clk);
        req_i       = req;
        fifo_full_i = full;
        data_i      = data;
        #1;
        last_step_cyc = cyc;
        e_ack  = '0;
        e_we   = 1'b0;
        e_data = '0;
        if (m_busy && req[m_g] && !full) begin
            e_ack  = 4'(1 << m_g);
            e_we   = 1'b1;
            e_data = data[m_g*8 +: 8];
        end
        check_eq("ack", 32'(ack_o), 32'(e_ack));
        check_eq("ack_onehot0", 32'($onehot0(ack_o)), 32'd1);
        check_eq("wr_en", 32'(fifo_wr_en_o), 32'(e_we));
        if (e_we) check_eq("wr_data", 32'(fifo_wr_data_o), 32'(e_data));
        check_eq("grant", 32'(grant_o), 32'(m_busy));
        check_eq("grant_id", 32'(grant_id_o), 32'(m_g));
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check_eq("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
`endif
        if (grant_o && !prev_grant) begin
            dut_grants.push_back(int'(grant_id_o));
            burst_wr.push_back(0);
        end
        prev_grant = grant_o;
        if (fifo_wr_en_o) begin
            dut_wr.push_back(int'(fifo_wr_data_o));
            wr_cyc.push_back(cyc);
            if (burst_wr.size() > 0) begin
                burst_wr[burst_wr.size()-1] += 1;
                check_eq("burst_le_max", 32'(burst_wr[burst_wr.size()-1] <= int'(MAX_BURST)), 32'd1);
            end
        end
        if (!m_busy) begin
            if (req != 4'b0) begin
                for (int i = 0; i < int'(NUM_REQ); i++) begin
                    int idx;
                    idx = (m_rr + i) % int'(NUM_REQ);
                    if (req[idx]) begin
                        m_g = idx;
                        break;
                    end
                end
                m_busy  = 1'b1;
                m_beats = 0;
            end
        end else begin
            if (req[m_g] && full && m_stall < 65535) m_stall++;
            if (e_we) m_beats++;
            if ((e_we && m_beats == int'(MAX_BURST)) || !req[m_g]) begin
                m_busy = 1'b0;
                m_rr   = (m_g + 1) % int'(NUM_REQ);
            end
        end
    endtask

    // Asynchronous reset in mid-cycle with inputs still requesting
    task automatic reset_mid();
        @(negedge clk);
        rst_i = 1'b1;
        #1;
        check_eq("rst_ack", 32'(ack_o), 32'd0);
        check_eq("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        check_eq("rst_grant", 32'(grant_o), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id_o), 32'd0);
        req_i       = '0;
        fifo_full_i = 1'b0;
        model_reset();
        @(negedge clk);
        rst_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int exp_grants[5];
        rst_i       = 1'b1;
        req_i       = '0;
        fifo_full_i = 1'b0;
        data_i      = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        step(4'b0000, 1'b0, 32'h0);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check_eq("init_stall", 32'(stall_cnt_o), 32'd0);
`endif

        // Single requester, data tracks the number of writes so far
        clear_logs();
        b = 0;
        while (dut_wr.size() < 6 && b < 30) begin
            step(4'b0001, 1'b0, 32'(8'h10 + 8'(dut_wr.size())));
            if (b == 0) first_req_cyc = last_step_cyc;
            b++;
        end
        check_eq("s1_nwr", 32'(dut_wr.size()), 32'd6);
        if (dut_wr.size() == 6) begin
            for (int i = 0; i < 6; i++) check_eq("s1_data", 32'(dut_wr[i]), 32'(8'h10 + i));
            check_eq("s1_latency", 32'(wr_cyc[0] - first_req_cyc), 32'd1);
            check_eq("s1_burst_span", 32'(wr_cyc[3] - wr_cyc[0]), 32'd3);
            check_eq("s1_idle_gap", 32'(wr_cyc[4] - wr_cyc[3]), 32'd2);
            check_eq("s1_second_burst", 32'(wr_cyc[5] - wr_cyc[4]), 32'd1);
        end
        check_eq("s1_first_gid", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd0);
        repeat (2) step(4'b0000, 1'b0, 32'h0);

        // Round-robin with all requesting
        reset_mid();
        clear_logs();
        exp_grants = '{0, 1, 2, 3, 0};
        b = 0;
        while (dut_grants.size() < 5 && b < 60) begin
            step(4'b1111, 1'b0, $urandom);
            b++;
        end
        check_eq("s2_ngrants", 32'(dut_grants.size()), 32'd5);
        if (dut_grants.size() >= 5) begin
            for (int i = 0; i < 5; i++) check_eq("s2_order", 32'(dut_grants[i]), 32'(exp_grants[i]));
            for (int i = 0; i < 4; i++) check_eq("s2_burst_len", 32'(burst_wr[i]), 32'(MAX_BURST));
        end
        repeat (2) step(4'b0000, 1'b0, 32'h0);

        // Full stall in the middle of requester 2's burst
        reset_mid();
        clear_logs();
        b = 0;
        while (dut_wr.size() < 2 && b < 10) begin
            step(4'b0100, 1'b0, $urandom);
            b++;
        end
        repeat (3) step(4'b0100, 1'b1, $urandom);
        check_eq("s3_no_wr_full", 32'(dut_wr.size()), 32'd2);
        b = 0;
        while (dut_wr.size() < 4 && b < 10) begin
            step(4'b0100, 1'b0, $urandom);
            b++;
        end
        repeat (2) step(4'b0000, 1'b0, 32'h0);
        check_eq("s3_nwr", 32'(dut_wr.size()), 32'd4);
        check_eq("s3_nbursts", 32'(burst_wr.size()), 32'd1);
        check_eq("s3_gid", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd2);
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        check_eq("s3_stall_cnt", 32'(stall_cnt_o), 32'd3);
`endif

        // Early drop by requester 1 while 3 waits; 3 must beat 0 (search starts at 2)
        reset_mid();
        clear_logs();
        b = 0;
        while (dut_wr.size() < 2 && b < 10) begin
            step(4'b1010, 1'b0, $urandom);
            b++;
        end
        step(4'b1001, 1'b0, $urandom);
        b = 0;
        while (dut_grants.size() < 2 && b < 10) begin
            step(4'b1001, 1'b0, $urandom);
            b++;
        end
        check_eq("s4_ngrants", 32'(dut_grants.size()), 32'd2);
        if (dut_grants.size() >= 2) begin
            check_eq("s4_first", 32'(dut_grants[0]), 32'd1);
            check_eq("s4_burst_len", 32'(burst_wr[0]), 32'd2);
            check_eq("s4_next", 32'(dut_grants[1]), 32'd3);
        end
        repeat (2) step(4'b0000, 1'b0, 32'h0);

        // Reset during requester 3's burst, then only requester 2 asks
        reset_mid();
        clear_logs();
        b = 0;
        while (dut_wr.size() < 2 && b < 10) begin
            step(4'b1000, 1'b0, $urandom);
            b++;
        end
        check_eq("s5_pre_grant", 32'(grant_o), 32'd1);
        reset_mid();
        clear_logs();
        repeat (2) step(4'b0100, 1'b0, $urandom);
        check_eq("s5_post_gid", 32'(dut_grants.size() > 0 ? dut_grants[0] : -1), 32'd2);
        repeat (2) step(4'b0000, 1'b0, 32'h0);

        // Full and drop together
        reset_mid();
        clear_logs();
        b = 0;
        while (dut_wr.size() < 1 && b < 10) begin
            step(4'b0010, 1'b0, $urandom);
            b++;
        end
        step(4'b0000, 1'b1, $urandom);
        check_eq("s6_no_wr", 32'(dut_wr.size()), 32'd1);
        step(4'b0101, 1'b0, $urandom);
        check_eq("s6_idle", 32'(grant_o), 32'd0);
        step(4'b0101, 1'b0, $urandom);
        check_eq("s6_next_gid", 32'(dut_grants.size() >= 2 ? dut_grants[1] : -1), 32'd2);
        repeat (2) step(4'b0000, 1'b0, 32'h0);

        // Randomized traffic against the model
        begin
            logic [3:0] r;
            r = '0;
            for (int n = 0; n < 1500; n++) begin
                if ($urandom_range(0, 299) == 0) begin
                    reset_mid();
                end else begin
                    if ($urandom_range(0, 3) == 0) r = 4'($urandom);
                    step(r, $urandom_range(0, 4) == 0, $urandom);
                end
            end
        end
        repeat (2) step(4'b0000, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
